// File: rtl/mem_output_logic_if.sv
// Load-return bus between the memory request side and mem_output_logic.
// The requester drives the request and BRAM read data; the block returns the aligned result.
interface mem_output_logic_if;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic [31:0] addr;
  logic [31:0] romDout;
  logic [31:0] ramDout;
  logic        flush;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;

  modport master (
    output memOp, memSize, addr, romDout, ramDout, flush,
    input  rdata, rvalid, misalign
  );

  modport slave (
    input  memOp, memSize, addr, romDout, ramDout, flush,
    output rdata, rvalid, misalign
  );
endinterface

// File: rtl/mem_output_logic.sv
// Load return path: captures load controls, selects ROM/RAM read data, aligns and extends it.
// Optional macro MEM_OUT_REG_EN adds a second register stage in front of the alignment.
module mem_output_logic #(
  parameter int RAM_SEL_BIT = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_output_logic_if.slave bus
);

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alignLoad(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? 32'(b) : {24'd0, b};
      2'b01:   r = sgn ? 32'(h) : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic        isLoad;
  logic        v1;
  logic [1:0]  offset_p1;
  logic [1:0]  size_p1;
  logic        isSigned_p1;
  logic        src_p1;

  logic        lastV;
  logic [31:0] lastData;
  logic [1:0]  lastOffset;
  logic [1:0]  lastSize;
  logic        lastSigned;
  logic        lastMis;

  logic [31:0] rdataQ;
  logic        rvalidQ;
  logic        misalignQ;

  assign isLoad = (bus.memOp == 2'b01) || (bus.memOp == 2'b10);

  // Stage 1: request controls; BRAM data arrives during the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) v1 <= 1'b0;
    else        v1 <= isLoad & ~bus.flush;
    offset_p1   <= bus.addr[1:0];
    size_p1     <= bus.memSize;
    isSigned_p1 <= (bus.memOp == 2'b10);
    src_p1      <= bus.addr[RAM_SEL_BIT];
  end

`ifdef MEM_OUT_REG_EN
  logic        v2;
  logic [31:0] data_p2;
  logic [1:0]  offset_p2;
  logic [1:0]  size_p2;
  logic        isSigned_p2;

  // Stage 2: BRAM data sampled one clk after the load, controls follow along
  always_ff @(posedge clk) begin
    if (!rst_n) v2 <= 1'b0;
    else        v2 <= v1 & ~bus.flush;
    data_p2     <= src_p1 ? bus.ramDout : bus.romDout;
    offset_p2   <= offset_p1;
    size_p2     <= size_p1;
    isSigned_p2 <= isSigned_p1;
  end

  assign lastV      = v2;
  assign lastData   = data_p2;
  assign lastOffset = offset_p2;
  assign lastSize   = size_p2;
  assign lastSigned = isSigned_p2;
`else
  assign lastV      = v1;
  assign lastData   = src_p1 ? bus.ramDout : bus.romDout;
  assign lastOffset = offset_p1;
  assign lastSize   = size_p1;
  assign lastSigned = isSigned_p1;
`endif

  assign lastMis = isMisaligned(lastSize, lastOffset);

  // Output stage: rdata only updates on a completed load so it holds between pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalidQ   <= 1'b0;
      misalignQ <= 1'b0;
      rdataQ    <= '0;
    end else begin
      rvalidQ   <= lastV;
      misalignQ <= lastV & lastMis;
      if (lastV) rdataQ <= lastMis ? '0 : alignLoad(lastData, lastSize, lastOffset, lastSigned);
    end
  end

  assign bus.rdata    = rdataQ;
  assign bus.rvalid   = rvalidQ;
  assign bus.misalign = misalignQ;

endmodule

// File: tb/tb_mem_output_logic.sv
// Directed bench for mem_output_logic: per-cycle stimulus table, rule-based expected outputs,
// and literal pins for the documented load scenarios.
module tb_mem_output_logic;

`ifdef MEM_OUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_output_logic_if bus();
  mem_output_logic #(.RAM_SEL_BIT(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [1:0]  sOp   [N];
  logic [1:0]  sSize [N];
  logic [31:0] sAddr [N];
  logic [31:0] sRom  [N];
  logic [31:0] sRam  [N];
  logic        sFlush[N];
  logic        sRstn [N];

  logic        eV[N];
  logic        eM[N];
  logic [31:0] eD[N];

  typedef struct { int cyc; logic v; logic [31:0] d; logic m; } pin_t;
  pin_t pins[$];

  int nTests = 0;
  int nFail  = 0;

  task automatic setLoad(input int c, input logic [1:0] op, input logic [1:0] size, input logic [31:0] a);
    sOp[c] = op; sSize[c] = size; sAddr[c] = a;
  endtask

  task automatic addPin(input int c, input logic v, input logic [31:0] d, input logic m);
    pin_t p;
    p.cyc = c; p.v = v; p.d = d; p.m = m;
    pins.push_back(p);
  endtask

  function automatic logic [31:0] modelData(input logic [31:0] w, input int nBytes, input int off, input bit sgn);
    longint unsigned mask, val;
    mask = (64'd1 << (8 * nBytes)) - 1;
    val  = (longint'(w) >> (8 * off)) & mask;
    if (sgn && nBytes < 4 && (((val >> (8 * nBytes - 1)) & 1) == 1)) val = val | ~mask;
    return val[31:0];
  endfunction

  task automatic buildModel();
    logic [31:0] held = 32'd0;
    for (int c = 0; c < N; c++) begin
      eV[c] = 1'b0; eM[c] = 1'b0;
      if (!sRstn[c]) held = 32'd0;
      else if (c - L >= 0) begin
        int j = c - L;
        bit alive = sRstn[j] && !sFlush[j] && (sOp[j] == 2'b01 || sOp[j] == 2'b10);
        for (int k = j + 1; k <= c; k++) if (!sRstn[k]) alive = 0;
        for (int k = j + 1; k < c; k++)  if (sFlush[k]) alive = 0;
        if (alive) begin
          int nb  = (sSize[j] == 2'b00) ? 1 : (sSize[j] == 2'b01) ? 2 : 4;
          int off = int'(sAddr[j][1:0]);
          logic [31:0] w = sAddr[j][31] ? sRam[j+1] : sRom[j+1];
          eV[c] = 1'b1;
          eM[c] = (off % nb) != 0;
          held  = eM[c] ? 32'd0 : modelData(w, nb, off, sOp[j] == 2'b10);
        end
      end
      eD[c] = held;
    end
  endtask

  task automatic check1(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got 0x%08h, want 0x%08h", name, c, act, exp);
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      sOp[c] = 2'b00; sSize[c] = 2'b00; sAddr[c] = 32'h0000_0000;
      sRom[c] = 32'hA000_0000 | 32'(c); sRam[c] = 32'hB000_0000 | 32'(c);
      sFlush[c] = 1'b0; sRstn[c] = 1'b1;
    end
    sRstn[0] = 1'b0; sRstn[1] = 1'b0;
    setLoad(1, 2'b01, 2'b10, 32'h0000_0000);
    setLoad(2, 2'b10, 2'b00, 32'h8000_0003); sRam[3]  = 32'h80FF_1234;
    setLoad(3, 2'b01, 2'b01, 32'h0000_0002); sRom[4]  = 32'hBEEF_0000;
    setLoad(4, 2'b10, 2'b01, 32'h0000_0002); sRom[5]  = 32'hBEEF_0000;
    setLoad(5, 2'b01, 2'b10, 32'h8000_0002);
    setLoad(6, 2'b11, 2'b10, 32'h8000_0002);
    setLoad(8, 2'b01, 2'b00, 32'h0000_0001); sRom[9]  = 32'h1122_3344;
    setLoad(9, 2'b01, 2'b10, 32'h8000_0000); sRam[10] = 32'hCAFE_F00D; sFlush[9] = 1'b1;
    setLoad(10, 2'b01, 2'b01, 32'h0000_0000); sRom[11] = 32'h5566_A5A5;
    setLoad(12, 2'b01, 2'b00, 32'h8000_0000); sRam[13] = 32'h0000_00EE;
    setLoad(13, 2'b01, 2'b10, 32'h8000_0000); sRstn[13] = 1'b0;
    setLoad(15, 2'b10, 2'b00, 32'h0000_0000); sRom[16] = 32'h0000_007F;
    setLoad(16, 2'b10, 2'b00, 32'h8000_0001); sRam[17] = 32'h0000_8000;
    setLoad(17, 2'b01, 2'b01, 32'h0000_0003);
    setLoad(18, 2'b10, 2'b11, 32'h8000_0000); sRam[19] = 32'h1234_5678;
    setLoad(19, 2'b01, 2'b00, 32'h0000_0002); sRom[20] = 32'hAABB_CCDD;
    setLoad(21, 2'b00, 2'b00, 32'h8000_0000);

    addPin(1, 1'b0, 32'h0000_0000, 1'b0);
    addPin(2, 1'b0, 32'h0000_0000, 1'b0);
    addPin(2 + L, 1'b1, 32'hFFFF_FF80, 1'b0);
    addPin(3 + L, 1'b1, 32'h0000_BEEF, 1'b0);
    addPin(4 + L, 1'b1, 32'hFFFF_BEEF, 1'b0);
    addPin(5 + L, 1'b1, 32'h0000_0000, 1'b1);
    addPin(6 + L, 1'b0, 32'h0000_0000, 1'b0);
    addPin(10 + L, 1'b1, 32'h0000_A5A5, 1'b0);
    addPin(13, 1'b0, 32'h0000_0000, 1'b0);
    addPin(14, 1'b0, 32'h0000_0000, 1'b0);
    addPin(15 + L, 1'b1, 32'h0000_007F, 1'b0);
    addPin(16 + L, 1'b1, 32'hFFFF_FF80, 1'b0);
    addPin(17 + L, 1'b1, 32'h0000_0000, 1'b1);
    addPin(18 + L, 1'b1, 32'h1234_5678, 1'b0);
    addPin(19 + L, 1'b1, 32'h0000_00BB, 1'b0);

    buildModel();

    fork
      begin
        for (int c = 0; c < N; c++) begin
          rst_n       = sRstn[c];
          bus.memOp   = sOp[c];
          bus.memSize = sSize[c];
          bus.addr    = sAddr[c];
          bus.romDout = sRom[c];
          bus.ramDout = sRam[c];
          bus.flush   = sFlush[c];
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int c = 0; c < N; c++) begin
          @(posedge clk);
          @(negedge clk);
          check1("rvalid", c, 32'(bus.rvalid), 32'(eV[c]));
          check1("misalign", c, 32'(bus.misalign), 32'(eM[c]));
          check1("rdata", c, bus.rdata, eD[c]);
          foreach (pins[i]) begin
            if (pins[i].cyc == c) begin
              check1("pin_rvalid", c, 32'(bus.rvalid), 32'(pins[i].v));
              check1("pin_rdata", c, bus.rdata, pins[i].d);
              check1("pin_misalign", c, 32'(bus.misalign), 32'(pins[i].m));
            end
          end
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_output_logic.md
MEM_OUTPUT_LOGIC -- requirements
Module: mem_output_logic

Interface
REQ-001 Parameter: RAM_SEL_BIT, default 31; addr bit that selects the source: 0 = ROM, 1 = RAM.
REQ-002 Port: clk, input, 1; sole clock, all state on rising edge.
REQ-003 Port: rst_n, input, 1; synchronous reset, active-low.
REQ-004 Port: memOp, input, 2; 00 none, 01 load unsigned, 10 load signed, 11 store.
REQ-005 Port: memSize, input, 2; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-006 Port: addr, input, 32; byte address of the request, sampled with memOp.
REQ-007 Port: romDout, input, 32; ROM port-B read data, valid one clk after the enabled read.
REQ-008 Port: ramDout, input, 32; RAM port-B read data, valid one clk after the enabled read.
REQ-009 Port: flush, input, 1; kills all in-flight loads.
REQ-010 Port: rdata, output, 32; aligned and extended load result.
REQ-011 Port: rvalid, output, 1; one-cycle pulse per completed load.
REQ-012 Port: misalign, output, 1; asserted with rvalid when the completed load was misaligned.

Function
REQ-013 A request is a load when memOp is 01 or 10; memOp 00 and 11 are ignored and produce no rvalid.
REQ-014 On a load, the block SHALL capture addr[1:0], memSize, signedness (memOp==10) and source (addr[RAM_SEL_BIT]) into stage 1, with valid bit v1.
REQ-015 Loads are fully pipelined: one new load per cycle accepted, no stall, no backpressure.
REQ-016 Without the macro, rvalid SHALL assert exactly 1 clk after the load cycle.
REQ-017 Source data is romDout when the captured source = 0, else ramDout.
REQ-018 Little-endian lane select: byte uses offset k -> bits [8k+7:8k]; half uses offset 0 -> [15:0], offset 2 -> [31:16]; word -> [31:0].
REQ-019 Extension: signed loads sign-extend from bit 7 (byte) or bit 15 (half); unsigned loads zero-extend; word loads are not extended.
REQ-020 Misaligned = half with addr[0]=1, or word/reserved with addr[1:0]!=00; then misalign=1 with rvalid and rdata=0.
REQ-021 rdata SHALL hold its last value when rvalid=0.
REQ-022 flush=1 SHALL clear all stage valid bits and also kill a load presented in the same cycle; rvalid is 0 in the following cycle(s) for those loads.
REQ-023 A load presented the cycle after flush is accepted normally.
REQ-024 Back-to-back loads to alternating sources SHALL each select their own captured source.

Reset
REQ-025 While rst_n=0 at a clk edge: rdata=0, rvalid=0, misalign=0, and all stage valid bits cleared.
REQ-026 A load in flight when reset asserts SHALL never produce rvalid, including after reset releases.
REQ-027 Loads presented during a cycle with rst_n=0 are discarded.

Configuration
REQ-028 Macro MEM_OUT_REG_EN: when defined, the BRAM data and stage-1 controls SHALL be registered once more (stage 2, valid v2) before alignment, so rvalid is asserted 2 clk after the load; the BRAM data is sampled at 1 clk.
REQ-029 With MEM_OUT_REG_EN defined, flush and reset SHALL clear both v1 and v2, and throughput remains one load per cycle.
REQ-030 Without MEM_OUT_REG_EN, there is a single stage, latency is 1, and there is no stage-2 logic.

Verification
REQ-031 Load signed byte, addr=0x8000_0003, ramDout=0x80FF_1234 -> rvalid at +1, rdata=0xFFFF_FF80, misalign=0.
REQ-032 Load unsigned half, addr=0x0000_0002, romDout=0xBEEF_0000 -> rdata=0x0000_BEEF; same load signed -> 0xFFFF_BEEF.
REQ-033 Load word, addr=0x8000_0002 -> rvalid=1, misalign=1, rdata=0; store (memOp=11) to the same addr -> no rvalid.
REQ-034 Loads on 3 consecutive cycles (ROM, RAM, ROM) with flush on the 2nd cycle -> rvalid only for the 1st load, and the 3rd load is returned the cycle after flush + 1.
REQ-035 Load issued, rst_n=0 on the next edge -> rvalid, rdata and misalign all 0, and no rvalid after release.
REQ-036 With MEM_OUT_REG_EN, repeat REQ-031 -> rvalid at +2 with an identical rdata, and back-to-back loads return on consecutive cycles.
